// File: rtl/regfile_mp.sv
// Multi-port register file with write-back and link write ports, optional r0 hardwiring,
// write-to-read bypass and a per-register busy scoreboard for decode hazard checks.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wb_en,
    input  logic [ADDR_W-1:0]          wb_num,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       lk_en,
    input  logic [ADDR_W-1:0]          lk_num,
    input  logic [DATA_W-1:0]          lk_data,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_num,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       set_en,
    input  logic [ADDR_W-1:0]          set_num,
    output logic                       busy_any
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam bit HAS_ZERO = (ZERO_REG != 0);
    localparam bit HAS_BYP  = (BYPASS != 0);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    logic wb_act;
    logic lk_act;
    logic set_act;

    // Accesses to a hardwired r0 are dropped here, so they neither write, bypass nor mark busy.
    assign wb_act  = wb_en  && !(HAS_ZERO && (wb_num  == '0));
    assign lk_act  = lk_en  && !(HAS_ZERO && (lk_num  == '0));
    assign set_act = set_en && !(HAS_ZERO && (set_num == '0));

    // Link write is issued last so it wins a same-index collision with write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (wb_act) begin
                regs_q[wb_num] <= wb_data;
            end
            if (lk_act) begin
                regs_q[lk_num] <= lk_data;
            end
        end
    end

    // A new producer marked this cycle supersedes a retiring write to the same register.
    always_comb begin
        busy_d = busy_q;
        if (wb_act) begin
            busy_d[wb_num] = 1'b0;
        end
        if (lk_act) begin
            busy_d[lk_num] = 1'b0;
        end
        if (set_act) begin
            busy_d[set_num] = 1'b1;
        end
        if (HAS_ZERO) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] idx;
        logic              hit_lk;
        logic              hit_wb;
        logic              is_zero;

        assign idx     = rd_num[k*ADDR_W +: ADDR_W];
        assign hit_lk  = HAS_BYP && lk_act && (lk_num == idx);
        assign hit_wb  = HAS_BYP && wb_act && (wb_num == idx);
        assign is_zero = HAS_ZERO && (idx == '0);

        assign rd_data[k*DATA_W +: DATA_W] = hit_lk  ? lk_data :
                                             hit_wb  ? wb_data :
                                             is_zero ? '0      : regs_q[idx];

        // A value forwarded this cycle already satisfies the reader.
        assign rd_busy[k] = busy_q[idx] && !(hit_lk || hit_wb);
    end

    assign busy_any = |rd_busy;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined CPU; successor to the single-write-port, two-read-port 32x32 file.
- Adds:
  - a configurable number of read ports;
  - a second write port for the JAL link write, which previously shared the write-back port;
  - optional register-0 hardwiring;
  - write-to-read bypass;
  - a per-register busy scoreboard for hazard detection.
- Sits between decode (reads, busy checks, destination marking) and write-back (writes).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; register count is 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never busy.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_en  in  1  write-back port write enable.
- wb_num  in  ADDR_W  write-back destination index.
- wb_data  in  DATA_W  write-back data.
- lk_en  in  1  link port write enable (JAL return address).
- lk_num  in  ADDR_W  link destination index.
- lk_data  in  DATA_W  link data.
- rd_num  in  NUM_RD*ADDR_W  read indices; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  port k's register has a pending producer.
- set_en  in  1  decode issues an instruction with destination set_num.
- set_num  in  ADDR_W  index to mark busy.
- busy_any  out  1  OR of all rd_busy bits.

Behaviour:
- Storage: 2**ADDR_W x DATA_W flops. Busy vector: 2**ADDR_W bits.
- Reset (rst_n low, asynchronous, independent of clk):
  - all registers cleared to 0;
  - all busy bits cleared.
  - Outputs during reset: rd_data = 0 (or the bypass value if BYPASS=1 and a write port matches), rd_busy = 0, busy_any = 0.
  - Reset asserted mid-write: the write is lost.
- Write, rising edge of clk:
  - if wb_en, reg[wb_num] <= wb_data;
  - if lk_en, reg[lk_num] <= lk_data.
  - wb_en and lk_en both asserted with wb_num == lk_num: link port wins.
  - ZERO_REG=1: writes to index 0 are discarded on both ports.
- Read: combinational, zero-latency.
  - BYPASS=0: rd_data[k] = reg[rd_num[k]].
  - BYPASS=1: if lk_en and lk_num matches, lk_data; else if wb_en and wb_num matches, wb_data; else reg[rd_num[k]].
  - Bypass priority matches write priority. No bypass for index 0 when ZERO_REG=1.
  - ZERO_REG=1: index 0 always reads 0.
- Scoreboard, per register i, on rising edge:
  - set_en && set_num == i: busy[i] <= 1. Set has priority over a same-cycle clear, because the new producer supersedes the retiring one.
  - Otherwise, (wb_en && wb_num == i) or (lk_en && lk_num == i): busy[i] <= 0.
  - ZERO_REG=1: busy[0] held at 0; set_num = 0 is ignored.
  - A write to a non-busy register is legal and leaves it non-busy.
- Busy outputs: rd_busy[k] = busy[rd_num[k]] && !(same-cycle write to rd_num[k] with BYPASS=1).
  - A value being written this cycle is not a hazard when bypassed.
  - With BYPASS=0, rd_busy follows the registered busy bit only.
- busy_any = |rd_busy.
- Multiple read ports may address the same index; each returns an identical result.
- No internal latency beyond one edge for writes and busy updates.

Test Plan:
- Reset then read: assert rst_n=0 without a clock edge, release, read r1..r31 -> all rd_data = 0 and rd_busy = 0.
- Basic write/read: wb_en, wb_num=5, wb_data=0xDEADBEEF; edge; rd_num port0=5 -> rd_data port0 = 0xDEADBEEF. Same write to index 0 with ZERO_REG=1 -> index 0 reads 0.
- Dual-write collision: wb_num=lk_num=31, wb_data=0x11, lk_data=0x22, both enabled; same cycle, port1 reads 31 -> 0x22 via bypass; after edge -> 0x22 stored. With BYPASS=0, same-cycle read returns the old value 0.
- Scoreboard with simultaneous set/clear: set_en, set_num=7; edge -> rd_busy=1 for a port reading 7, busy_any=1. Next cycle wb_en to 7 with data 0x55 and set_en=7 together: during that cycle rd_busy=0 and rd_data=0x55 (bypass); after the edge busy remains 1. Further wb to 7 with set_en=0 -> busy clears.
- Async reset mid-operation: busy[3]=1, reg[3]=0x1234; drop rst_n between edges -> rd_data = 0 and rd_busy = 0 immediately, without waiting for an edge.
- NUM_RD=4 sweep: ports 0..3 read indices 2,2,9,0 after writing 0xA to r2 and 0xB to r9 -> rd_data = 0xA, 0xA, 0xB, 0.
